// File: rtl/mole_pkg.sv
// Shared definitions for the mole scheduler: FSM states, per-difficulty
// timing table, LFSR polynomial and a small popcount helper.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_POLY = 8'hB8;

  // Entry [0] is easy, entry [3] is hardest; all values are in game ticks.
  localparam logic [3:0][7:0] SPAWN_IVL  = {8'd12, 8'd20, 8'd30, 8'd40};
  localparam logic [3:0][7:0] MOLE_LIFE  = {8'd18, 8'd30, 8'd45, 8'd60};
  localparam logic [3:0][3:0] MAX_ACTIVE = {4'd6, 4'd4, 4'd3, 4'd2};

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/mole_free_finder.sv
// Combinational search for the first free hole at or above a start index,
// wrapping past the top hole back to hole 0.
module mole_free_finder #(
  parameter int NUM_HOLES = 8
) (
  input  logic [NUM_HOLES-1:0] free,
  input  logic [2:0]           start,
  output logic [2:0]           idx,
  output logic                 found
);

  logic [3:0] pos;

  // Scan offsets from farthest to nearest so the nearest free hole wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = NUM_HOLES - 1; k >= 0; k--) begin
      pos = {1'b0, start} + 4'(k);
      if (pos >= 4'(NUM_HOLES)) pos = pos - 4'(NUM_HOLES);
      if (free[pos[2:0]]) begin
        idx   = pos[2:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: spawns moles into free holes from an LFSR,
// ages them per game tick and turns taps/expiries into hit, miss and escape counts.
module mole_scheduler #(
  parameter int         NUM_HOLES = 8,
  parameter int         LIFE_W    = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 run,
  input  logic                 pause,
  input  logic [1:0]           difficulty,
  input  logic [NUM_HOLES-1:0] tap,
  output logic [NUM_HOLES-1:0] holes,
  output logic [3:0]           hit_cnt,
  output logic [3:0]           miss_cnt,
  output logic [3:0]           escape_cnt,
  output logic [3:0]           active_cnt,
  output logic                 busy
);
  import mole_pkg::*;

  state_t               state_reg;
  logic [NUM_HOLES-1:0] occ_reg;
  logic [NUM_HOLES-1:0] occ_next;
  logic [NUM_HOLES-1:0] hit_mask;
  logic [NUM_HOLES-1:0] miss_mask;
  logic [NUM_HOLES-1:0] expire_mask;
  logic [NUM_HOLES-1:0] spawn_mask;
  logic [NUM_HOLES-1:0] life_one;
  logic [7:0]           lfsr_reg;
  logic [7:0]           timer_reg;
  logic [1:0]           diff_reg;
  logic                 live;
  logic                 live_tick;
  logic                 abort;
  logic                 spawn_ok;
  logic                 found;
  logic [2:0]           start_idx;
  logic [2:0]           spawn_idx;
  logic [3:0]           active_now;

  // Dropping run wins over everything else, so no event is counted on an abort.
  assign live        = (state_reg == ST_PLAY) && run;
  assign live_tick   = live && tick;
  assign abort       = (state_reg != ST_IDLE) && !run;
  assign hit_mask    = live ? (tap & occ_reg) : '0;
  assign miss_mask   = live ? (tap & ~occ_reg) : '0;
  assign expire_mask = live_tick ? (occ_reg & life_one & ~tap) : '0;
  assign active_now  = popcount8(8'(occ_reg));
  assign start_idx   = 3'({5'd0, lfsr_reg[2:0]} % NUM_HOLES);

  // Free set is taken before this cycle's clears, so a just-vacated hole is skipped.
  mole_free_finder #(.NUM_HOLES(NUM_HOLES)) u_finder (
    .free  (~occ_reg),
    .start (start_idx),
    .idx   (spawn_idx),
    .found (found)
  );

  assign spawn_ok = live_tick && (timer_reg == 8'd0) && found &&
                    (active_now < MAX_ACTIVE[diff_reg]);
  assign occ_next = abort ? '0 : ((occ_reg & ~hit_mask & ~expire_mask) | spawn_mask);

  generate
    for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
      logic [LIFE_W-1:0] life;

      assign spawn_mask[gi] = spawn_ok && (spawn_idx == 3'(gi));
      assign life_one[gi]   = (life == LIFE_W'(1));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          life <= '0;
        end else if (abort || hit_mask[gi] || expire_mask[gi]) begin
          life <= '0;
        end else if (spawn_mask[gi]) begin
          life <= LIFE_W'(MOLE_LIFE[diff_reg]);
        end else if (live_tick && occ_reg[gi]) begin
          life <= life - LIFE_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      occ_reg    <= '0;
      lfsr_reg   <= LFSR_SEED;
      timer_reg  <= 8'd0;
      diff_reg   <= 2'd0;
      holes      <= '0;
      hit_cnt    <= 4'd0;
      miss_cnt   <= 4'd0;
      escape_cnt <= 4'd0;
      active_cnt <= 4'd0;
      busy       <= 1'b0;
    end else begin
      occ_reg    <= occ_next;
      active_cnt <= popcount8(8'(occ_next));
      hit_cnt    <= popcount8(8'(hit_mask));
      miss_cnt   <= popcount8(8'(miss_mask));
      escape_cnt <= popcount8(8'(expire_mask));

      // Timer is reloaded with interval-1 so spawns land exactly one interval apart.
      if (live_tick) begin
        lfsr_reg  <= {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? LFSR_POLY : 8'h00);
        timer_reg <= (timer_reg == 8'd0) ? (SPAWN_IVL[diff_reg] - 8'd1)
                                         : (timer_reg - 8'd1);
      end

      case (state_reg)
        ST_IDLE: begin
          holes <= '0;
          busy  <= run;
          if (run) begin
            state_reg <= ST_PLAY;
            diff_reg  <= difficulty;
            timer_reg <= 8'd0;
          end
        end
        ST_PLAY: begin
          if (!run) begin
            state_reg <= ST_IDLE;
            holes     <= '0;
            busy      <= 1'b0;
          end else if (pause) begin
            state_reg <= ST_PAUSED;
            holes     <= '0;
            busy      <= 1'b1;
          end else begin
            holes <= occ_next;
            busy  <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!run) begin
            state_reg <= ST_IDLE;
            holes     <= '0;
            busy      <= 1'b0;
          end else if (!pause) begin
            state_reg <= ST_PLAY;
            holes     <= occ_next;
            busy      <= 1'b1;
          end else begin
            holes <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          holes     <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
